// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold / shift right / shift left / parallel load,
// with a saturating shift counter. Define USR_ROTATE_EN to let rot recirculate the exiting bit.
module universal_shift_register #(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             n_clr,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             si_r,
   input  logic             si_l,
   input  logic             rot,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             so_r,
   output logic             so_l,
   output logic             done
);

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   logic [CNT_W-1:0] cnt;
   logic             in_r;
   logic             in_l;
   logic             is_shift;

`ifdef USR_ROTATE_EN
   assign in_r = rot ? q[0]       : si_r;
   assign in_l = rot ? q[WIDTH-1] : si_l;
`else
   logic unused_rot;
   assign unused_rot = rot;
   assign in_r       = si_r;
   assign in_l       = si_l;
`endif

   assign is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);

   always_ff @(posedge clk) begin
      if (reset || !n_clr) begin
         q    <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (en) begin
         case (mode)
            MODE_SHR:  q <= {in_r, q[WIDTH-1:1]};
            MODE_SHL:  q <= {q[WIDTH-2:0], in_l};
            MODE_LOAD: q <= d;
            default:   q <= q;
         endcase

         // Load restarts the count even if this edge would have completed it.
         if (mode == MODE_LOAD) begin
            cnt  <= '0;
            done <= 1'b0;
         end else if (is_shift && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX - 1'b1)
               done <= 1'b1;
         end
      end
   end

   assign q_bar = ~q;
   assign so_r  = q[0];
   assign so_l  = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8); rotate expectations follow USR_ROTATE_EN.
module tb_universal_shift_register;

   logic       clk = 1'b0;
   logic       reset, n_clr, en, si_r, si_l, rot;
   logic [1:0] mode;
   logic [7:0] d, q, q_bar;
   logic       so_r, so_l, done;

   int tests = 0;
   int fails = 0;

   universal_shift_register #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .n_clr(n_clr), .en(en), .mode(mode), .d(d),
      .si_r(si_r), .si_l(si_l), .rot(rot), .q(q), .q_bar(q_bar),
      .so_r(so_r), .so_l(so_l), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] en_seq;
      logic [7:0] exp_l [5];
      logic [7:0] rot_q1, rot_q8;

      // Reset with arbitrary inputs
      reset = 1'b1; n_clr = 1'b1; en = 1'b1; mode = 2'b11; d = 8'h5A;
      si_r = 1'b1; si_l = 1'b1; rot = 1'b0;
      tick();
      tick();
      chk("rst_q", q, 8'h00);
      reset = 1'b0; en = 1'b0; mode = 2'b00;
      tick();
      chk("rst_q_after", q, 8'h00);
      chk("rst_qbar", q_bar, 8'hFF);
      chk("rst_done", {7'b0, done}, 8'h00);
      chk("rst_so_r", {7'b0, so_r}, 8'h00);
      chk("rst_so_l", {7'b0, so_l}, 8'h00);

      // Load A5, shift right 8 times with zeros
      en = 1'b1; mode = 2'b11; d = 8'hA5;
      tick();
      chk("load_a5", q, 8'hA5);
      chk("load_so_l", {7'b0, so_l}, 8'h01);
      mode = 2'b01; si_r = 1'b0;
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("shr_so_r_%0d", i), {7'b0, so_r}, {7'b0, pat[i]});
         chk($sformatf("shr_done_%0d", i), {7'b0, done}, 8'h00);
         tick();
      end
      chk("shr_final_q", q, 8'h00);
      chk("shr_final_done", {7'b0, done}, 8'h01);
      si_r = 1'b1;
      tick();
      chk("shr_sat_q", q, 8'h80);
      chk("shr_sat_done", {7'b0, done}, 8'h01);
      mode = 2'b00;
      tick();
      chk("hold_q", q, 8'h80);
      chk("hold_done", {7'b0, done}, 8'h01);

      // Shift left with enable gaps
      mode = 2'b11; d = 8'h81;
      tick();
      chk("load_81", q, 8'h81);
      chk("load_81_done", {7'b0, done}, 8'h00);
      mode = 2'b10; si_l = 1'b1;
      en_seq = 8'b0001_0101;
      exp_l[0] = 8'h03; exp_l[1] = 8'h03; exp_l[2] = 8'h07; exp_l[3] = 8'h07; exp_l[4] = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         en = en_seq[i];
         tick();
         chk($sformatf("shl_q_%0d", i), q, exp_l[i]);
         chk($sformatf("shl_done_%0d", i), {7'b0, done}, 8'h00);
      end

      // Clear beats load
      en = 1'b1; n_clr = 1'b0; mode = 2'b11; d = 8'hFF;
      tick();
      chk("clr_q", q, 8'h00);
      chk("clr_done", {7'b0, done}, 8'h00);
      n_clr = 1'b1;
      tick();
      chk("clr_release_q", q, 8'hFF);
      chk("clr_release_qbar", q_bar, 8'h00);
      chk("clr_release_done", {7'b0, done}, 8'h00);

      // Load colliding with terminal count
      mode = 2'b01; si_r = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("pre_coll_q", q, 8'h01);
      chk("pre_coll_done", {7'b0, done}, 8'h00);
      mode = 2'b11; d = 8'h3C;
      tick();
      chk("coll_q", q, 8'h3C);
      chk("coll_done", {7'b0, done}, 8'h00);
      si_r = 1'b1; si_l = 1'b1;
      for (int i = 0; i < 7; i++) begin
         mode = (i % 2 == 0) ? 2'b01 : 2'b10;
         tick();
      end
      chk("mixed7_done", {7'b0, done}, 8'h00);
      mode = 2'b01;
      tick();
      chk("mixed8_done", {7'b0, done}, 8'h01);

      // en low holds everything, then reset aborts
      en = 1'b0; mode = 2'b11; d = 8'h00;
      pat = q;
      tick();
      chk("en_low_q", q, pat);
      chk("en_low_done", {7'b0, done}, 8'h01);
      reset = 1'b1;
      tick();
      chk("rst_mid_q", q, 8'h00);
      chk("rst_mid_done", {7'b0, done}, 8'h00);
      reset = 1'b0;

      // Rotate right
`ifdef USR_ROTATE_EN
      rot_q1 = 8'h80; rot_q8 = 8'h01;
`else
      rot_q1 = 8'h00; rot_q8 = 8'h00;
`endif
      en = 1'b1; mode = 2'b11; d = 8'h01;
      tick();
      mode = 2'b01; rot = 1'b1; si_r = 1'b0;
      tick();
      chk("rot_q1", q, rot_q1);
      for (int i = 0; i < 7; i++) tick();
      chk("rot_q8", q, rot_q8);
      chk("rot_done", {7'b0, done}, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- WIDTH-bit register bank built from the team's enable/clear/reset flip-flop cell semantics.
- Provides hold, shift-right, shift-left and parallel-load modes, with serial outputs in both directions.
- Sits directly downstream of single-bit storage cells as the word-level consumer, and feeds serial links and counters.
- A shift counter flags when a parallel-loaded word has been fully shifted out.

Parameters:
- WIDTH, 8, register width in bits; legal range >= 2.
- CNT_W, $clog2(WIDTH+1), shift-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- n_clr  input  1  synchronous active-low clear; priority below reset.
- en  input  1  operation enable; when low, the register holds.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- si_r  input  1  serial in for shift right; enters at bit WIDTH-1.
- si_l  input  1  serial in for shift left; enters at bit 0.
- rot  input  1  rotate request; used only when USR_ROTATE_EN is defined.
- q  output  WIDTH  register contents (registered).
- q_bar  output  WIDTH  ~q (combinational from q).
- so_r  output  1  q[0]; the bit leaving on a right shift.
- so_l  output  1  q[WIDTH-1]; the bit leaving on a left shift.
- done  output  1  high once WIDTH shifts have occurred since the last load (registered).

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- Priority per edge: reset > ~n_clr > en.
- Reset values: q=0, q_bar=all ones, so_r=0, so_l=0, cnt=0, done=0.
- n_clr low with reset low: same values as reset (q=0, cnt=0, done=0). mode and en are ignored.
- en low (reset low, n_clr high): q, cnt and done hold, regardless of mode.
- en high, mode 00: hold; cnt and done unchanged.
- en high, mode 01: q <= {si_r, q[WIDTH-1:1]}.
- en high, mode 10: q <= {q[WIDTH-2:0], si_l}.
- en high, mode 11: q <= d; cnt <= 0; done <= 0.
- Shift counter: each shift (mode 01 or 10, en high) increments cnt, saturating at WIDTH.
  - done <= 1 on the edge where cnt reaches WIDTH.
  - Further shifts keep cnt=WIDTH and done=1; the q shift itself still occurs.
- Latency: q, so_r, so_l and done reflect an operation one cycle after the sampling edge. q_bar tracks q with zero cycles of added delay.
- Mixed-direction shifts all count toward cnt. The direction change has no special handling.
- Reset or clear asserted in the middle of a shift sequence aborts it: cnt=0, done=0 on that edge.
- A load issued on the same edge that would complete the count wins: cnt=0, done=0.
- The counter only clears on reset, clear or load. If done is already 1 and a shift occurs, done stays 1 until the next load.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined: with rot=1 during a shift, the serial input is replaced by the exiting bit.
  - Right shift: q <= {q[0], q[WIDTH-1:1]}.
  - Left shift: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Rotates count toward cnt/done like ordinary shifts.
- Not defined: the rot port exists but is ignored; shifts always use si_r and si_l.

Test Plan:
- Reset sequence, WIDTH=8: reset=1 for 2 cycles with arbitrary inputs, then low -> q=8'h00, q_bar=8'hFF, done=0.
- Load then shift right: load d=8'hA5; then 8 cycles of mode=01, en=1, si_r=0.
  - so_r sequence = 1,0,1,0,0,1,0,1.
  - done=1 after the 8th shift; q=8'h00.
- Shift left with enable gaps: load 8'h81; mode=10, si_l=1; en toggled 1,0,1,0,1.
  - q = 8'h03, 8'h03, 8'h07, 8'h07, 8'h0F.
  - cnt advances only on en=1 cycles; done stays 0.
- Priority: reset=0, n_clr=0, en=1, mode=11, d=8'hFF -> q=8'h00.
  - Then n_clr=1, same inputs -> q=8'hFF, done=0.
- Load collides with terminal count: after 7 shifts following a load, issue mode=11, d=8'h3C -> q=8'h3C, done stays 0.
  - Then 8 shifts -> done=1.
- USR_ROTATE_EN defined, load 8'h01, rot=1, mode=01:
  - After 1 shift: q=8'h80.
  - After 8 shifts: q=8'h01, done=1.
  - Same stimulus with the macro undefined and si_r=0 -> q=8'h00.
